imem_boot_ctrl: RTL
===================

# imem_boot_ctrl

Boot/load controller for the single-cycle RV32I instruction memory. It accepts a stream of 32-bit instruction words over a valid/ready loader port and writes them sequentially into IMEM from word 0. It holds the core in reset until the program is fully written, then releases it. It also supports re-loading on request and flags overflow errors.

## Interface
Parameters:
- DEPTH, 32, IMEM depth in words. Power of two, ≥ 2.
- AW, $clog2(DEPTH), IMEM word-address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- boot_req  in  1  single-cycle pulse that starts a (re)load
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader instruction word
- ld_last  in  1  marks the final word of the stream; qualified by ld_valid
- ld_ready  out  1  controller can accept a word
- mem_we  out  1  IMEM write enable
- mem_waddr  out  AW  IMEM word address (byte address = mem_waddr<<2)
- mem_wdata  out  32  IMEM write data
- cpu_rst_n  out  1  core reset, active-low; low in every state except RUN
- boot_done  out  1  high in RUN
- boot_err  out  1  high in ERR
- word_cnt  out  AW+1  program words written in the current or last load

## Operation
- States are IDLE, LOAD, FLUSH, RUN and ERR. Reset enters IDLE.
- From IDLE, RUN or ERR, boot_req moves to LOAD and clears word_cnt.
- boot_req in LOAD restarts the load: word_cnt returns to 0. A handshake in that same cycle is discarded and not written.
- boot_req in FLUSH is ignored.
- ld_ready = (state == LOAD). Registered, no combinational path from ld_valid.
- Accept occurs when ld_valid && ld_ready. An accepted word at word_cnt < DEPTH is registered:
  - mem_we = 1, mem_waddr = word_cnt[AW-1:0], mem_wdata = ld_data in the next cycle
  - word_cnt increments
- Accept with ld_last: the word is written as above and the state becomes FLUSH. From FLUSH the controller enters RUN unconditionally after one cycle.
- Overflow: an accept while word_cnt == DEPTH performs no write and enters ERR, including when ld_last is set. word_cnt stays at DEPTH.
- ERR keeps cpu_rst_n low. Only boot_req or rst_n leaves ERR.
- RUN ignores the loader port. ld_ready = 0.
- The core fetch path does not pass through this block. IMEM's read port is driven by the PC directly.

## Timing
- All outputs are registered.
- Reset values: state IDLE, ld_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_rst_n 0, boot_done 0, boot_err 0, word_cnt 0.
- Accept in cycle N produces the write strobe in cycle N+1. mem_we is high for exactly one cycle per accepted word.
- Back-to-back accepts give one write per cycle.
- Last word accepted in cycle N:
  - N+1: write, state FLUSH
  - N+2: state RUN, cpu_rst_n = 1, boot_done = 1
  - The core therefore never fetches before the final write has landed.
- boot_req in cycle N (from RUN, IDLE or ERR):
  - N+1: state LOAD, cpu_rst_n = 0, boot_done = 0, boot_err = 0, ld_ready = 1
- An rst_n assertion mid-load aborts immediately. No further mem_we is issued, and IMEM contents are left as-is.

## Configuration
- IMEM_BOOT_CKSUM_EN defined:
  - The ld_last word is a checksum and is not written to IMEM.
  - The controller keeps a running 32-bit XOR of all written words, cleared on entry to LOAD.
  - On the last accept it compares the checksum word to that XOR:
    - equal → FLUSH. Since no write occurs, FLUSH is only the one-cycle delay.
    - unequal → ERR.
  - word_cnt excludes the checksum word.
  - Overflow is checked only against data words: a checksum word arriving at word_cnt == DEPTH is legal.
- Undefined: no checksum logic. ld_last is a normal data word.

## Test plan
- Reset, then boot_req, then 3 words 0x00110463, 0x00209663, 0x0020C663 with ld_last on the third → writes to addresses 0, 1, 2 in consecutive cycles; cpu_rst_n rises 2 cycles after the third accept; word_cnt = 3.
- Stream DEPTH+1 words (no ld_last until word DEPTH+1) → DEPTH writes, no write for the extra word, boot_err = 1, cpu_rst_n stays 0.
- boot_req after 2 of 5 words, then a full 4-word stream → second stream writes addresses 0–3; the discarded handshake produces no mem_we.
- rst_n low during a LOAD burst → all outputs take their reset values asynchronously, and no mem_we follows.
- From RUN, boot_req → cpu_rst_n low in the next cycle; a reload of 1 word → RUN again with word_cnt = 1.
- With IMEM_BOOT_CKSUM_EN: words 0x1, 0x2 then checksum 0x3 → RUN, word_cnt = 2. Same stream with checksum 0x4 → ERR.

Source files
------------

// File: rtl/imem_boot_ctrl.sv
// Boot/load controller: streams loader words into IMEM from word 0 and holds the core
// in reset until the program has landed. Optional checksum word: IMEM_BOOT_CKSUM_EN.
module imem_boot_ctrl #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          boot_req,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic          cpu_rst_n,
    output logic          boot_done,
    output logic          boot_err,
    output logic [AW:0]   word_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_FLUSH = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   word_cnt_q, word_cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_waddr_q, mem_waddr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          ld_ready_q, cpu_rst_n_q, boot_done_q, boot_err_q;
`ifdef IMEM_BOOT_CKSUM_EN
    logic [31:0]   xor_q, xor_d;
`endif

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef IMEM_BOOT_CKSUM_EN
        xor_d       = xor_q;
`endif
        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (boot_req) begin
                    state_d    = S_LOAD;
                    word_cnt_d = '0;
`ifdef IMEM_BOOT_CKSUM_EN
                    xor_d      = '0;
`endif
                end
            end
            S_LOAD: begin
                // A restart wins over any handshake in the same cycle; that word is dropped.
                if (boot_req) begin
                    word_cnt_d = '0;
`ifdef IMEM_BOOT_CKSUM_EN
                    xor_d      = '0;
`endif
                end else if (ld_valid) begin
`ifdef IMEM_BOOT_CKSUM_EN
                    if (ld_last) begin
                        state_d = (ld_data == xor_q) ? S_FLUSH : S_ERR;
                    end else if (word_cnt_q == FULL) begin
                        state_d = S_ERR;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_cnt_q[AW-1:0];
                        mem_wdata_d = ld_data;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        xor_d       = xor_q ^ ld_data;
                    end
`else
                    if (word_cnt_q == FULL) begin
                        state_d = S_ERR;
                    end else begin
                        mem_we_d    = 1'b1;
                        mem_waddr_d = word_cnt_q[AW-1:0];
                        mem_wdata_d = ld_data;
                        word_cnt_d  = word_cnt_q + 1'b1;
                        if (ld_last) begin
                            state_d = S_FLUSH;
                        end
                    end
`endif
                end
            end
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they line up with it in the register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            ld_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            boot_done_q <= 1'b0;
            boot_err_q  <= 1'b0;
`ifdef IMEM_BOOT_CKSUM_EN
            xor_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_ready_q  <= (state_d == S_LOAD);
            cpu_rst_n_q <= (state_d == S_RUN);
            boot_done_q <= (state_d == S_RUN);
            boot_err_q  <= (state_d == S_ERR);
`ifdef IMEM_BOOT_CKSUM_EN
            xor_q       <= xor_d;
`endif
        end
    end

    assign ld_ready  = ld_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign boot_done = boot_done_q;
    assign boot_err  = boot_err_q;
    assign word_cnt  = word_cnt_q;

endmodule
